// File: rtl/prim_generic_pipe.sv
// Elastic multi-stage register pipeline with valid/ready on both sides.
// Empty stages let later words advance (bubble collapse); clr_i flushes every stage.
module prim_generic_pipe #(
   parameter int unsigned            Width      = 1,
   parameter int unsigned            Depth      = 2,
   parameter logic [Width-1:0]       ResetValue = '0,
   localparam int unsigned           CntW       = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [Width-1:0] data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [Width-1:0] data_o,
   output logic [CntW-1:0]  depth_o
);

   // Handshake: a word moves on an edge where valid and ready are both 1.
   // ready_o is combinational from ready_i, so consumers must not loop ready_i back from it.

   if (Depth < 1 || Depth > 16) begin : g_depth_check
      $error("prim_generic_pipe: Depth must be in 1..16");
   end

   logic [Depth-1:0] r_valid;
   logic [Width-1:0] r_data [Depth];

   logic [Depth-1:0] w_adv;
   logic [Depth-1:0] w_in_valid;
   logic [Width-1:0] w_in_data [Depth];
   logic [CntW-1:0]  w_depth;

   // A stage may advance unless it and every stage downstream of it are full
   // while the consumer stalls. Written as a flat AND to avoid a self-referencing chain.
   always_comb begin
      w_adv = '0;
      for (int k = 0; k < int'(Depth); k++) begin
         logic v_all_full;
         v_all_full = 1'b1;
         for (int j = k; j < int'(Depth); j++) begin
            v_all_full = v_all_full & r_valid[j];
         end
         w_adv[k] = ready_i | ~v_all_full;
      end
   end

   assign ready_o = w_adv[0] & ~clr_i;

   assign w_in_valid[0] = valid_i & ready_o;
   assign w_in_data[0]  = data_i;

   for (genvar k = 1; k < int'(Depth); k++) begin : g_stage_in
      assign w_in_valid[k] = r_valid[k-1];
      assign w_in_data[k]  = r_data[k-1];
   end

   // Data registers only load with a valid word so idle cycles do not toggle them.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= '0;
         for (int k = 0; k < int'(Depth); k++) begin
            r_data[k] <= ResetValue;
         end
      end else if (clr_i) begin
         r_valid <= '0;
         for (int k = 0; k < int'(Depth); k++) begin
            r_data[k] <= ResetValue;
         end
      end else begin
         for (int k = 0; k < int'(Depth); k++) begin
            if (w_adv[k]) begin
               r_valid[k] <= w_in_valid[k];
               if (w_in_valid[k]) begin
                  r_data[k] <= w_in_data[k];
               end
            end
         end
      end
   end

   always_comb begin
      w_depth = '0;
      for (int k = 0; k < int'(Depth); k++) begin
         w_depth = w_depth + CntW'(r_valid[k]);
      end
   end

   assign depth_o = w_depth;
   assign valid_o = r_valid[Depth-1];
   assign data_o  = r_data[Depth-1];

endmodule

// File: tb/tb_prim_generic_pipe.sv
// Directed bench for prim_generic_pipe: Depth 3, 4 and 1 instances sharing clock and reset.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_prim_generic_pipe;

   logic clk;
   logic rst_ni;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Depth=3 instance
   logic       d3_clr, d3_vi, d3_ro, d3_vo, d3_ri;
   logic [7:0] d3_di, d3_do;
   logic [1:0] d3_depth;

   // Depth=4 instance
   logic       d4_clr, d4_vi, d4_ro, d4_vo, d4_ri;
   logic [7:0] d4_di, d4_do;
   logic [2:0] d4_depth;

   // Depth=1 instance
   logic       d1_clr, d1_vi, d1_ro, d1_vo, d1_ri;
   logic [7:0] d1_di, d1_do;
   logic [0:0] d1_depth;

   prim_generic_pipe #(.Width(8), .Depth(3), .ResetValue(8'h5A)) dut3 (
      .clk_i(clk), .rst_ni(rst_ni), .clr_i(d3_clr),
      .valid_i(d3_vi), .ready_o(d3_ro), .data_i(d3_di),
      .valid_o(d3_vo), .ready_i(d3_ri), .data_o(d3_do), .depth_o(d3_depth)
   );

   prim_generic_pipe #(.Width(8), .Depth(4), .ResetValue(8'hC3)) dut4 (
      .clk_i(clk), .rst_ni(rst_ni), .clr_i(d4_clr),
      .valid_i(d4_vi), .ready_o(d4_ro), .data_i(d4_di),
      .valid_o(d4_vo), .ready_i(d4_ri), .data_o(d4_do), .depth_o(d4_depth)
   );

   prim_generic_pipe #(.Width(8), .Depth(1), .ResetValue(8'h00)) dut1 (
      .clk_i(clk), .rst_ni(rst_ni), .clr_i(d1_clr),
      .valid_i(d1_vi), .ready_o(d1_ro), .data_i(d1_di),
      .valid_o(d1_vo), .ready_i(d1_ri), .data_o(d1_do), .depth_o(d1_depth)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] w_exp;
      rst_ni = 1'b1;
      d3_clr = 0; d3_vi = 0; d3_di = 0; d3_ri = 0;
      d4_clr = 0; d4_vi = 0; d4_di = 0; d4_ri = 0;
      d1_clr = 0; d1_vi = 0; d1_di = 0; d1_ri = 0;
      #2 rst_ni = 1'b0;
      #1;
      chk("rst_valid3", 32'(d3_vo), 32'h0);
      chk("rst_data3",  32'(d3_do), 32'h5A);
      chk("rst_depth3", 32'(d3_depth), 32'h0);
      chk("rst_ready3", 32'(d3_ro), 32'h1);
      chk("rst_data4",  32'(d4_do), 32'hC3);
      step();
      rst_ni = 1'b1;

      // Latency: one word into empty Depth=3 pipe
      d3_vi = 1; d3_di = 8'hA5; d3_ri = 1; #1;
      chk("lat_ready_c0", 32'(d3_ro), 32'h1);
      chk("lat_valid_c0", 32'(d3_vo), 32'h0);
      step(); d3_vi = 0; #1;
      chk("lat_depth_c1", 32'(d3_depth), 32'h1);
      chk("lat_valid_c1", 32'(d3_vo), 32'h0);
      step(); #1;
      chk("lat_depth_c2", 32'(d3_depth), 32'h1);
      chk("lat_valid_c2", 32'(d3_vo), 32'h0);
      step(); #1;
      chk("lat_valid_c3", 32'(d3_vo), 32'h1);
      chk("lat_data_c3",  32'(d3_do), 32'hA5);
      chk("lat_depth_c3", 32'(d3_depth), 32'h1);
      step(); #1;
      chk("lat_valid_c4", 32'(d3_vo), 32'h0);
      chk("lat_depth_c4", 32'(d3_depth), 32'h0);

      // Streaming 0x01..0x10 with ready_i held high
      for (int c = 0; c < 21; c++) begin
         step();
         if (c < 16) begin
            d3_vi = 1; d3_di = 8'(c + 1);
            exp_q.push_back(8'(c + 1));
         end else begin
            d3_vi = 0;
         end
         #1;
         if (c < 16) chk("strm_ready", 32'(d3_ro), 32'h1);
         chk("strm_valid", 32'(d3_vo), 32'((c >= 3) && (c <= 18)));
         if (d3_vo) begin
            w_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            chk("strm_data", 32'(d3_do), 32'(w_exp));
         end
      end
      chk("strm_drained", 32'(exp_q.size()), 32'h0);

      // Backpressure fill, Depth=3
      step(); d3_ri = 0; d3_vi = 1; d3_di = 8'h11; #1;
      chk("bp_ready_c0", 32'(d3_ro), 32'h1);
      step(); d3_di = 8'h22; #1;
      chk("bp_ready_c1", 32'(d3_ro), 32'h1);
      chk("bp_depth_c1", 32'(d3_depth), 32'h1);
      step(); d3_di = 8'h33; #1;
      chk("bp_ready_c2", 32'(d3_ro), 32'h1);
      chk("bp_depth_c2", 32'(d3_depth), 32'h2);
      step(); d3_di = 8'h44; #1;
      chk("bp_ready_c3", 32'(d3_ro), 32'h0);
      chk("bp_depth_c3", 32'(d3_depth), 32'h3);
      chk("bp_data_c3",  32'(d3_do), 32'h11);
      step(); #1;
      chk("bp_ready_c4", 32'(d3_ro), 32'h0);
      chk("bp_valid_c4", 32'(d3_vo), 32'h1);
      chk("bp_data_c4",  32'(d3_do), 32'h11);
      step(); d3_ri = 1; #1;
      chk("bp_ready_c5", 32'(d3_ro), 32'h1);
      chk("bp_data_c5",  32'(d3_do), 32'h11);
      step(); d3_vi = 0; #1;
      chk("bp_data_c6",  32'(d3_do), 32'h22);
      chk("bp_depth_c6", 32'(d3_depth), 32'h3);
      step(); #1;
      chk("bp_data_c7",  32'(d3_do), 32'h33);
      step(); #1;
      chk("bp_data_c8",  32'(d3_do), 32'h44);
      chk("bp_depth_c8", 32'(d3_depth), 32'h1);
      step(); #1;
      chk("bp_valid_c9", 32'(d3_vo), 32'h0);
      chk("bp_depth_c9", 32'(d3_depth), 32'h0);

      // Flush of a full pipe, then a flush while empty
      step(); d3_ri = 0; d3_vi = 1; d3_di = 8'h61;
      step(); d3_di = 8'h62;
      step(); d3_di = 8'h63;
      step(); d3_di = 8'h64; d3_clr = 1; #1;
      chk("fl_ready_clr", 32'(d3_ro), 32'h0);
      chk("fl_depth_pre", 32'(d3_depth), 32'h3);
      step(); d3_clr = 0; d3_vi = 0; d3_ri = 1; #1;
      chk("fl_depth",  32'(d3_depth), 32'h0);
      chk("fl_valid",  32'(d3_vo), 32'h0);
      chk("fl_data",   32'(d3_do), 32'h5A);
      step(); d3_clr = 1; d3_vi = 1; d3_di = 8'h77; #1;
      chk("fl_ready_empty", 32'(d3_ro), 32'h0);
      step(); d3_clr = 0; d3_vi = 0; #1;
      chk("fl_depth2", 32'(d3_depth), 32'h0);
      for (int c = 0; c < 3; c++) begin
         step(); #1;
         chk("fl_no_leak", 32'(d3_vo), 32'h0);
      end

      // Bubble collapse, Depth=4
      step(); d4_ri = 0; d4_vi = 1; d4_di = 8'hAA; #1;
      chk("bub_ready_c0", 32'(d4_ro), 32'h1);
      step(); d4_vi = 0;
      step();
      step(); d4_vi = 1; d4_di = 8'hBB; #1;
      chk("bub_ready_c3", 32'(d4_ro), 32'h1);
      step(); d4_vi = 0; #1;
      chk("bub_depth_c4", 32'(d4_depth), 32'h2);
      step(); #1;
      chk("bub_valid_c5", 32'(d4_vo), 32'h1);
      chk("bub_data_c5",  32'(d4_do), 32'hAA);
      step(); #1;
      chk("bub_depth_c6", 32'(d4_depth), 32'h2);
      chk("bub_ready_c6", 32'(d4_ro), 32'h1);
      step(); d4_ri = 1; #1;
      chk("bub_data_c7",  32'(d4_do), 32'hAA);
      step(); #1;
      chk("bub_valid_c8", 32'(d4_vo), 32'h1);
      chk("bub_data_c8",  32'(d4_do), 32'hBB);
      step(); #1;
      chk("bub_depth_c9", 32'(d4_depth), 32'h0);

      // Fill Depth=4 to capacity, then async reset between edges
      d4_ri = 0;
      for (int c = 0; c < 4; c++) begin
         step(); d4_vi = 1; d4_di = 8'(8'hE1 + c); #1;
         chk("fill_ready", 32'(d4_ro), 32'h1);
      end
      step(); d4_di = 8'hE5; #1;
      chk("fill_ready_full", 32'(d4_ro), 32'h0);
      chk("fill_depth_full", 32'(d4_depth), 32'h4);
      chk("fill_data",       32'(d4_do), 32'hE1);
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_valid4", 32'(d4_vo), 32'h0);
      chk("arst_depth4", 32'(d4_depth), 32'h0);
      chk("arst_data4",  32'(d4_do), 32'hC3);
      chk("arst_ready4", 32'(d4_ro), 32'h1);
      step(); rst_ni = 1'b1; d4_vi = 0;

      // Resume after reset: Depth=4 latency
      step(); d4_ri = 1; d4_vi = 1; d4_di = 8'hD1;
      step(); d4_di = 8'hD2;
      step(); d4_vi = 0; #1;
      chk("rs_valid_c2", 32'(d4_vo), 32'h0);
      step(); #1;
      chk("rs_valid_c3", 32'(d4_vo), 32'h0);
      step(); #1;
      chk("rs_valid_c4", 32'(d4_vo), 32'h1);
      chk("rs_data_c4",  32'(d4_do), 32'hD1);
      step(); #1;
      chk("rs_data_c5",  32'(d4_do), 32'hD2);
      step(); #1;
      chk("rs_valid_c6", 32'(d4_vo), 32'h0);

      // Depth=1 single elastic register
      step(); d1_ri = 0; d1_vi = 1; d1_di = 8'h09; #1;
      chk("d1_ready_c0", 32'(d1_ro), 32'h1);
      step(); d1_di = 8'h0A; #1;
      chk("d1_ready_c1", 32'(d1_ro), 32'h0);
      chk("d1_data_c1",  32'(d1_do), 32'h09);
      chk("d1_depth_c1", 32'(d1_depth), 32'h1);
      step(); d1_ri = 1; #1;
      chk("d1_ready_c2", 32'(d1_ro), 32'h1);
      step(); d1_ri = 0; d1_vi = 0; #1;
      chk("d1_valid_c3", 32'(d1_vo), 32'h1);
      chk("d1_data_c3",  32'(d1_do), 32'h0A);
      step(); d1_ri = 1; #1;
      chk("d1_data_c4",  32'(d1_do), 32'h0A);
      step(); #1;
      chk("d1_valid_c5", 32'(d1_vo), 32'h0);
      chk("d1_depth_c5", 32'(d1_depth), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
